// File: rtl/tri_port_regfile_ctrl.sv
// tri_port_regfile_ctrl
// Request-side controller for tri_port_regfile. It accepts insert, lookup,
// read and free requests, allocates the lowest free entry on insert, drives
// the regfile read/write/CAM ports, and returns lookup/read results on one
// held response channel.
module tri_port_regfile_ctrl #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 8,
  parameter int NUMBER_ENTRY              = 4
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  // insert request
  input  logic                                   insert_valid_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   insert_data_in,
  output logic                                   insert_ready_out,
  output logic [NUMBER_ENTRY-1:0]                insert_entry_decoded_out,
  // lookup request
  input  logic                                   lookup_valid_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   lookup_key_in,
  output logic                                   lookup_ready_out,
  // read request
  input  logic                                   read_valid_in,
  input  logic [NUMBER_ENTRY-1:0]                read_entry_decoded_in,
  output logic                                   read_ready_out,
  // free request (always accepted)
  input  logic                                   free_valid_in,
  input  logic [NUMBER_ENTRY-1:0]                free_entry_decoded_in,
  // response channel
  output logic                                   resp_valid_out,
  input  logic                                   resp_ready_in,
  output logic                                   resp_hit_out,
  output logic [NUMBER_ENTRY-1:0]                resp_entry_decoded_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   resp_data_out,
  output logic [$clog2(NUMBER_ENTRY+1)-1:0]      occupancy_out,
  // regfile ports
  output logic                                   rf_read_en_out,
  output logic                                   rf_write_en_out,
  output logic                                   rf_cam_en_out,
  output logic [NUMBER_ENTRY-1:0]                rf_read_entry_addr_decoded_out,
  output logic [NUMBER_ENTRY-1:0]                rf_write_entry_addr_decoded_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   rf_cam_entry_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   rf_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   rf_read_entry_in,
  input  logic [NUMBER_ENTRY-1:0]                rf_cam_result_decoded_in
);

  localparam int OCC_W = $clog2(NUMBER_ENTRY + 1);
  localparam int DW    = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int NE    = NUMBER_ENTRY;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAM_WAIT = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  // Lowest set bit of v as a one-hot vector; zero when v is zero.
  function automatic logic [NE-1:0] lowest_one(input logic [NE-1:0] v);
    logic [NE-1:0] r;
    r = {NE{1'b0}};
    for (int i = NE - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = {NE{1'b0}};
        r[i] = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Number of set bits in v.
  function automatic logic [OCC_W-1:0] popcount(input logic [NE-1:0] v);
    logic [OCC_W-1:0] c;
    c = {OCC_W{1'b0}};
    for (int i = 0; i < NE; i++) begin
      c = c + OCC_W'(v[i]);
    end
    return c;
  endfunction

  // State
  state_t           state_q, state_d;
  logic [NE-1:0]    alloc_q, alloc_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [NE-1:0]    rd_addr_q, rd_addr_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_hit_q, resp_hit_d;
  logic [NE-1:0]    resp_entry_q, resp_entry_d;
  logic [DW-1:0]    resp_data_q, resp_data_d;

  // Handshake helpers
  logic             insert_ready_s;
  logic             insert_fire_s;
  logic [NE-1:0]    insert_onehot_s;
  logic [NE-1:0]    free_mask_s;
  logic             lookup_ready_s;
  logic             read_ready_s;
  logic             lookup_fire_s;
  logic             read_fire_s;
  logic [NE-1:0]    match_s;

  // Insert side: the write port is independent of the FSM, so only a full
  // alloc vector (or reset) stalls an insert.
  always_comb begin
    free_mask_s     = free_valid_in ? free_entry_decoded_in : {NE{1'b0}};
    insert_ready_s  = ~reset_in & ~(&alloc_q);
    insert_fire_s   = insert_valid_in & insert_ready_s;
    insert_onehot_s = lowest_one(~alloc_q);
    // Allocation uses the pre-edge vector; the chosen bit is clear there, so
    // a same-cycle free can never cancel it.
    alloc_d         = (alloc_q & ~free_mask_s) |
                      (insert_fire_s ? insert_onehot_s : {NE{1'b0}});
    occ_d           = occ_q + OCC_W'(insert_fire_s) - popcount(free_mask_s & alloc_q);
  end

  // Allocation vector and occupancy registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      alloc_q <= {NE{1'b0}};
      occ_q   <= {OCC_W{1'b0}};
    end else begin
      alloc_q <= alloc_d;
      occ_q   <= occ_d;
    end
  end

  // FSM next-state, request readiness and response capture.
  always_comb begin
    state_d        = state_q;
    rd_addr_d      = rd_addr_q;
    resp_valid_d   = resp_valid_q;
    resp_hit_d     = resp_hit_q;
    resp_entry_d   = resp_entry_q;
    resp_data_d    = resp_data_q;
    lookup_ready_s = 1'b0;
    read_ready_s   = 1'b0;
    lookup_fire_s  = 1'b0;
    read_fire_s    = 1'b0;
    // CAM hits are qualified by the vector as it stands after this cycle's free.
    match_s        = rf_cam_result_decoded_in & alloc_q & ~free_mask_s;
    case (state_q)
      ST_IDLE: begin
        lookup_ready_s = ~reset_in;
        read_ready_s   = ~reset_in & ~lookup_valid_in;
        lookup_fire_s  = lookup_valid_in & lookup_ready_s;
        read_fire_s    = read_valid_in & read_ready_s;
        if (lookup_fire_s) begin
          state_d = ST_CAM_WAIT;
        end else if (read_fire_s) begin
          state_d   = ST_RD_WAIT;
          rd_addr_d = read_entry_decoded_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAM_WAIT: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_hit_d   = |match_s;
        resp_entry_d = lowest_one(match_s);
        resp_data_d  = {DW{1'b0}};
      end
      ST_RD_WAIT: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_hit_d   = |(rd_addr_q & alloc_q);
        resp_entry_d = rd_addr_q;
        resp_data_d  = rf_read_entry_in;
      end
      ST_RESP: begin
        if (resp_ready_in) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state, pending read address and held response registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= {NE{1'b0}};
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_entry_q <= {NE{1'b0}};
      resp_data_q  <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_entry_q <= resp_entry_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Regfile port drive; address/data buses are zeroed when their enable is low.
  always_comb begin
    rf_write_en_out                 = insert_fire_s;
    rf_write_entry_addr_decoded_out = insert_fire_s ? insert_onehot_s : {NE{1'b0}};
    rf_write_entry_out              = insert_fire_s ? insert_data_in : {DW{1'b0}};
    insert_entry_decoded_out        = insert_fire_s ? insert_onehot_s : {NE{1'b0}};
    rf_cam_en_out                   = lookup_fire_s;
    rf_cam_entry_out                = lookup_fire_s ? lookup_key_in : {DW{1'b0}};
    rf_read_en_out                  = read_fire_s;
    rf_read_entry_addr_decoded_out  = read_fire_s ? read_entry_decoded_in : {NE{1'b0}};
  end

  assign insert_ready_out       = insert_ready_s;
  assign lookup_ready_out       = lookup_ready_s;
  assign read_ready_out         = read_ready_s;
  assign resp_valid_out         = resp_valid_q;
  assign resp_hit_out           = resp_hit_q;
  assign resp_entry_decoded_out = resp_entry_q;
  assign resp_data_out          = resp_data_q;
  assign occupancy_out          = occ_q;

endmodule

// File: tb/tb_tri_port_regfile_ctrl.sv
// Scoreboard bench for tri_port_regfile_ctrl with a behavioural regfile.
module tb_tri_port_regfile_ctrl;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       insert_valid_in;
  logic [7:0] insert_data_in;
  logic       insert_ready_out;
  logic [3:0] insert_entry_decoded_out;
  logic       lookup_valid_in;
  logic [7:0] lookup_key_in;
  logic       lookup_ready_out;
  logic       read_valid_in;
  logic [3:0] read_entry_decoded_in;
  logic       read_ready_out;
  logic       free_valid_in;
  logic [3:0] free_entry_decoded_in;
  logic       resp_valid_out;
  logic       resp_ready_in;
  logic       resp_hit_out;
  logic [3:0] resp_entry_decoded_out;
  logic [7:0] resp_data_out;
  logic [2:0] occupancy_out;
  logic       rf_read_en_out, rf_write_en_out, rf_cam_en_out;
  logic [3:0] rf_read_entry_addr_decoded_out, rf_write_entry_addr_decoded_out;
  logic [7:0] rf_cam_entry_out, rf_write_entry_out;
  logic [7:0] rf_read_entry_in;
  logic [3:0] rf_cam_result_decoded_in;

  tri_port_regfile_ctrl #(.SINGLE_ENTRY_SIZE_IN_BITS(8), .NUMBER_ENTRY(4)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .insert_valid_in(insert_valid_in), .insert_data_in(insert_data_in),
    .insert_ready_out(insert_ready_out), .insert_entry_decoded_out(insert_entry_decoded_out),
    .lookup_valid_in(lookup_valid_in), .lookup_key_in(lookup_key_in),
    .lookup_ready_out(lookup_ready_out),
    .read_valid_in(read_valid_in), .read_entry_decoded_in(read_entry_decoded_in),
    .read_ready_out(read_ready_out),
    .free_valid_in(free_valid_in), .free_entry_decoded_in(free_entry_decoded_in),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .resp_hit_out(resp_hit_out), .resp_entry_decoded_out(resp_entry_decoded_out),
    .resp_data_out(resp_data_out), .occupancy_out(occupancy_out),
    .rf_read_en_out(rf_read_en_out), .rf_write_en_out(rf_write_en_out),
    .rf_cam_en_out(rf_cam_en_out),
    .rf_read_entry_addr_decoded_out(rf_read_entry_addr_decoded_out),
    .rf_write_entry_addr_decoded_out(rf_write_entry_addr_decoded_out),
    .rf_cam_entry_out(rf_cam_entry_out), .rf_write_entry_out(rf_write_entry_out),
    .rf_read_entry_in(rf_read_entry_in),
    .rf_cam_result_decoded_in(rf_cam_result_decoded_in)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural regfile: write at the edge, read/CAM results one cycle after enable.
  logic [7:0] mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] rd_mux;
  logic [3:0] cam_vec;
  always_comb begin
    rd_mux  = 8'h00;
    cam_vec = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (rf_read_entry_addr_decoded_out[i]) rd_mux = rd_mux | mem[i];
      cam_vec[i] = (mem[i] == rf_cam_entry_out);
    end
  end
  always @(posedge clk_in) begin
    for (int i = 0; i < 4; i++) begin
      if (rf_write_en_out && rf_write_entry_addr_decoded_out[i]) mem[i] <= rf_write_entry_out;
    end
    if (rf_read_en_out) rf_read_entry_in <= rd_mux;
    if (rf_cam_en_out)  rf_cam_result_decoded_in <= cam_vec;
  end

  typedef struct packed {
    logic       hit;
    logic [3:0] entry;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every response consumed by the handshake is compared to the scoreboard.
  always @(negedge clk_in) begin
    if (!reset_in && resp_valid_out && resp_ready_in) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_hit",   {31'd0, resp_hit_out},          {31'd0, e.hit});
        check("resp_entry", {28'd0, resp_entry_decoded_out}, {28'd0, e.entry});
        check("resp_data",  {24'd0, resp_data_out},          {24'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] ins_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       read_done;

  initial begin
    reset_in = 1'b1;
    insert_valid_in = 1'b0; insert_data_in = 8'h00;
    lookup_valid_in = 1'b0; lookup_key_in = 8'h00;
    read_valid_in = 1'b0;   read_entry_decoded_in = 4'b0000;
    free_valid_in = 1'b0;   free_entry_decoded_in = 4'b0000;
    resp_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_resp_valid", {31'd0, resp_valid_out}, 32'd0);
    check("rst_occupancy",  {29'd0, occupancy_out},  32'd0);
    check("rst_rf_en", {29'd0, rf_read_en_out, rf_write_en_out, rf_cam_en_out}, 32'd0);
    reset_in = 1'b0;
    tick();

    // Fill all four entries.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] oh;
      oh = 4'b0001 << i;
      insert_valid_in = 1'b1;
      insert_data_in  = ins_data[i];
      #1;
      check("ins_ready",   {31'd0, insert_ready_out},          32'd1);
      check("ins_entry",   {28'd0, insert_entry_decoded_out},  {28'd0, oh});
      check("ins_wr_addr", {28'd0, rf_write_entry_addr_decoded_out}, {28'd0, oh});
      check("ins_wr_data", {24'd0, rf_write_entry_out},        {24'd0, ins_data[i]});
      tick();
    end
    insert_valid_in = 1'b0;
    #1;
    check("full_occupancy", {29'd0, occupancy_out},    32'd4);
    check("full_ins_ready", {31'd0, insert_ready_out}, 32'd0);
    tick();

    // Lookup 0x33 with two-cycle latency.
    lookup_valid_in = 1'b1; lookup_key_in = 8'h33;
    #1;
    check("lk_cam_en",  {31'd0, rf_cam_en_out},    32'd1);
    check("lk_cam_key", {24'd0, rf_cam_entry_out}, 32'h33);
    exp_q.push_back('{hit: 1'b1, entry: 4'b0100, data: 8'h00});
    tick();
    lookup_valid_in = 1'b0;
    check("lk_lat1_valid", {31'd0, resp_valid_out}, 32'd0);
    tick();
    check("lk_lat2_valid", {31'd0, resp_valid_out}, 32'd1);
    tick();
    wait_drain("lk_drain");

    // Read entry 0010, hold the response for three cycles.
    resp_ready_in = 1'b0;
    read_valid_in = 1'b1; read_entry_decoded_in = 4'b0010;
    #1;
    check("rd_en",   {31'd0, rf_read_en_out}, 32'd1);
    check("rd_addr", {28'd0, rf_read_entry_addr_decoded_out}, 32'h2);
    exp_q.push_back('{hit: 1'b1, entry: 4'b0010, data: 8'h22});
    tick();
    read_valid_in = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("hold_valid", {31'd0, resp_valid_out},         32'd1);
      check("hold_hit",   {31'd0, resp_hit_out},           32'd1);
      check("hold_entry", {28'd0, resp_entry_decoded_out}, 32'h2);
      check("hold_data",  {24'd0, resp_data_out},          32'h22);
      check("hold_lk_ready", {31'd0, lookup_ready_out},    32'd0);
      tick();
    end
    resp_ready_in = 1'b1;
    wait_drain("rd_drain");
    tick();

    // Free 0100 and insert 0x55 together while full: insert stalls one cycle.
    free_valid_in = 1'b1; free_entry_decoded_in = 4'b0100;
    insert_valid_in = 1'b1; insert_data_in = 8'h55;
    #1;
    check("fi_ready_stall", {31'd0, insert_ready_out}, 32'd0);
    check("fi_wr_en_stall", {31'd0, rf_write_en_out},  32'd0);
    tick();
    free_valid_in = 1'b0; free_entry_decoded_in = 4'b0000;
    #1;
    check("fi_occ_after_free", {29'd0, occupancy_out},           32'd3);
    check("fi_ready",          {31'd0, insert_ready_out},        32'd1);
    check("fi_entry",          {28'd0, insert_entry_decoded_out}, 32'h4);
    tick();
    insert_valid_in = 1'b0;
    check("fi_occ_refill", {29'd0, occupancy_out}, 32'd4);
    lookup_valid_in = 1'b1; lookup_key_in = 8'h33;
    exp_q.push_back('{hit: 1'b0, entry: 4'b0000, data: 8'h00});
    tick();
    lookup_valid_in = 1'b0;
    wait_drain("miss_drain");
    tick();

    // Lookup and read together: lookup wins, read follows after the handshake.
    lookup_valid_in = 1'b1; lookup_key_in = 8'h11;
    read_valid_in = 1'b1;   read_entry_decoded_in = 4'b1000;
    #1;
    check("pri_lk_ready", {31'd0, lookup_ready_out}, 32'd1);
    check("pri_rd_ready", {31'd0, read_ready_out},   32'd0);
    check("pri_rd_en",    {31'd0, rf_read_en_out},   32'd0);
    exp_q.push_back('{hit: 1'b1, entry: 4'b0001, data: 8'h00});
    tick();
    lookup_valid_in = 1'b0;
    read_done = 1'b0;
    for (int k = 0; k < 10 && !read_done; k++) begin
      #1;
      if (read_ready_out) begin
        check("pri_rd_after_resp", exp_q.size(), 32'd0);
        exp_q.push_back('{hit: 1'b1, entry: 4'b1000, data: 8'h44});
        read_done = 1'b1;
      end
      tick();
    end
    read_valid_in = 1'b0;
    check("pri_rd_accepted", {31'd0, read_done}, 32'd1);
    wait_drain("pri_drain");
    tick();

    // Asynchronous reset while the controller waits on the CAM.
    lookup_valid_in = 1'b1; lookup_key_in = 8'h22;
    tick();
    lookup_valid_in = 1'b0;
    #1;
    reset_in = 1'b1;
    #1;
    check("arst_resp_valid", {31'd0, resp_valid_out}, 32'd0);
    check("arst_occupancy",  {29'd0, occupancy_out},  32'd0);
    check("arst_rf_en", {29'd0, rf_read_en_out, rf_write_en_out, rf_cam_en_out}, 32'd0);
    tick();
    reset_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("arst_no_resp", {31'd0, resp_valid_out}, 32'd0);
    end
    check("arst_ins_ready", {31'd0, insert_ready_out}, 32'd1);
    check("end_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
